// File: rtl/kiwi_pkg.sv
// Shared definitions for the fetch0 stage: opcode constants used by the
// predecoder and the state encoding of the redirect FSM.
package kiwi_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } f0_state_t;

endpackage

// File: rtl/fetch0_stage_if.sv
// Bundle between the instruction queue, the fetch0 stage, decode and the
// PC generator. The slave side is the fetch0 stage itself; the master side
// is whatever feeds it and consumes its outputs.
interface fetch0_stage_if #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
);

    logic                     iq0_vld_i;
    logic                     iq1_vld_i;
    logic [PC_W-1:0]          iq0_pc_i;
    logic [PC_W-1:0]          iq1_pc_i;
    logic [INST_W-1:0]        iq0_inst_i;
    logic [INST_W-1:0]        iq1_inst_i;
    logic                     stall_iq_o;
    logic                     flush_iq_o;

    logic                     stall_i;
    logic                     flush_i;

    logic [1:0]               f0_vld_o;
    logic [1:0][PC_W-1:0]     f0_pc_o;
    logic [1:0][INST_W-1:0]   f0_inst_o;
    logic [1:0]               f0_is_br_o;
    logic [1:0]               f0_is_jal_o;
    logic [1:0]               f0_is_jalr_o;

    logic                     redirect_vld_o;
    logic [PC_W-1:0]          redirect_pc_o;

    modport master (
        output iq0_vld_i, iq1_vld_i, iq0_pc_i, iq1_pc_i, iq0_inst_i, iq1_inst_i,
        output stall_i, flush_i,
        input  stall_iq_o, flush_iq_o,
        input  f0_vld_o, f0_pc_o, f0_inst_o, f0_is_br_o, f0_is_jal_o, f0_is_jalr_o,
        input  redirect_vld_o, redirect_pc_o
    );

    modport slave (
        input  iq0_vld_i, iq1_vld_i, iq0_pc_i, iq1_pc_i, iq0_inst_i, iq1_inst_i,
        input  stall_i, flush_i,
        output stall_iq_o, flush_iq_o,
        output f0_vld_o, f0_pc_o, f0_inst_o, f0_is_br_o, f0_is_jal_o, f0_is_jalr_o,
        output redirect_vld_o, redirect_pc_o
    );

endinterface

// File: rtl/fetch0_predecode.sv
// Combinational predecoder for one fetch slot: classifies control-flow
// opcodes and computes the JAL target so fetch can redirect early.
module fetch0_predecode
    import kiwi_pkg::*;
#(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic              vld,
    input  logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] inst,
    output logic              is_br,
    output logic              is_jal,
    output logic              is_jalr,
    output logic [PC_W-1:0]   jal_target
);

    logic [6:0]  opcode;
    logic [20:0] jal_imm;
    logic        unused_rd;

    assign opcode    = inst[6:0];
    assign unused_rd = ^inst[11:7];

    // Classify the opcode; a flag only means something for a valid slot.
    always_comb begin
        is_br   = vld && (opcode == OP_BRANCH);
        is_jal  = vld && (opcode == OP_JAL);
        is_jalr = vld && (opcode == OP_JALR);
    end

    // J-type immediate reassembled, sign-extended and added to the slot PC.
    always_comb begin
        jal_imm    = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        jal_target = pc + {{(PC_W-21){jal_imm[20]}}, jal_imm};
    end

endmodule

// File: rtl/fetch0_stage.sv
// Fetch stage 0: takes instruction pairs from the instruction queue,
// registers them towards decode with predecode flags, and turns a JAL into
// a one-cycle redirect towards the PC generator plus a queue invalidate.
module fetch0_stage
    import kiwi_pkg::*;
#(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch0_stage_if.slave bus
);

    f0_state_t              state;
    logic [1:0]             vld_q;
    logic [1:0]             br_q;
    logic [1:0]             jal_q;
    logic [1:0]             jalr_q;
    logic                   redir_q;
    logic                   flush_iq_q;
    logic [1:0][PC_W-1:0]   pc_q;
    logic [1:0][INST_W-1:0] inst_q;
    logic [PC_W-1:0]        redirect_pc_q;

    logic [1:0]             pd_br;
    logic [1:0]             pd_jal;
    logic [1:0]             pd_jalr;
    logic [PC_W-1:0]        tgt0;
    logic [PC_W-1:0]        tgt1;
    logic                   stall_iq;
    logic                   accept;
    logic                   jal0;
    logic                   jal1;
    logic                   take_jal;
    logic [1:0]             keep;

    fetch0_predecode #(.PC_W(PC_W), .INST_W(INST_W)) u_pd0 (
        .vld        (bus.iq0_vld_i),
        .pc         (bus.iq0_pc_i),
        .inst       (bus.iq0_inst_i),
        .is_br      (pd_br[0]),
        .is_jal     (pd_jal[0]),
        .is_jalr    (pd_jalr[0]),
        .jal_target (tgt0)
    );

    fetch0_predecode #(.PC_W(PC_W), .INST_W(INST_W)) u_pd1 (
        .vld        (bus.iq1_vld_i),
        .pc         (bus.iq1_pc_i),
        .inst       (bus.iq1_inst_i),
        .is_br      (pd_br[1]),
        .is_jal     (pd_jal[1]),
        .is_jalr    (pd_jalr[1]),
        .jal_target (tgt1)
    );

    // Accept decision: the queue is held while decode stalls or while a
    // redirect is in flight; a slot0 JAL kills slot1 and wins the redirect.
    always_comb begin
        stall_iq = bus.stall_i || flush_iq_q || (state == ST_REDIR);
        accept   = bus.iq0_vld_i && bus.iq1_vld_i && !stall_iq && !bus.flush_i;
        jal0     = accept && pd_jal[0];
        jal1     = accept && pd_jal[1];
        take_jal = jal0 || jal1;
        keep     = {!jal0, 1'b1};
    end

    // Redirect FSM with registered valids, flags and one-cycle redirect pulse;
    // a backend flush beats everything, including a same-cycle JAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            vld_q      <= 2'b00;
            br_q       <= 2'b00;
            jal_q      <= 2'b00;
            jalr_q     <= 2'b00;
            redir_q    <= 1'b0;
            flush_iq_q <= 1'b0;
        end else if (bus.flush_i) begin
            state      <= ST_RUN;
            vld_q      <= 2'b00;
            br_q       <= 2'b00;
            jal_q      <= 2'b00;
            jalr_q     <= 2'b00;
            redir_q    <= 1'b0;
            flush_iq_q <= 1'b0;
        end else if (accept) begin
            state      <= take_jal ? ST_REDIR : ST_RUN;
            vld_q      <= keep;
            br_q       <= pd_br & keep;
            jal_q      <= pd_jal & keep;
            jalr_q     <= pd_jalr & keep;
            redir_q    <= take_jal;
            flush_iq_q <= take_jal;
        end else begin
            state      <= ST_RUN;
            redir_q    <= 1'b0;
            flush_iq_q <= 1'b0;
            if (!bus.stall_i) begin
                vld_q  <= 2'b00;
                br_q   <= 2'b00;
                jal_q  <= 2'b00;
                jalr_q <= 2'b00;
            end
        end
    end

    // Slot payload and redirect target are only captured on accept, so they
    // need no reset and simply hold through decode stalls.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q[0]   <= bus.iq0_pc_i;
            pc_q[1]   <= bus.iq1_pc_i;
            inst_q[0] <= bus.iq0_inst_i;
            inst_q[1] <= bus.iq1_inst_i;
            if (take_jal) begin
                redirect_pc_q <= jal0 ? tgt0 : tgt1;
            end
        end
    end

    assign bus.stall_iq_o     = stall_iq;
    assign bus.flush_iq_o     = flush_iq_q;
    assign bus.f0_vld_o       = vld_q;
    assign bus.f0_pc_o        = pc_q;
    assign bus.f0_inst_o      = inst_q;
    assign bus.f0_is_br_o     = br_q;
    assign bus.f0_is_jal_o    = jal_q;
    assign bus.f0_is_jalr_o   = jalr_q;
    assign bus.redirect_vld_o = redir_q;
    assign bus.redirect_pc_o  = redirect_pc_q;

endmodule

// File: tb/tb_fetch0_stage.sv
// Directed bench for fetch0_stage: pair issue, JAL redirects in either slot,
// branch/JALR flagging, decode stall, backend flush and reset mid-redirect.
module tb_fetch0_stage;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_JAL16 = 32'h0100006F;
    localparam logic [31:0] I_JALM8 = 32'hFF9FF06F;
    localparam logic [31:0] I_BEQ   = 32'h00000063;
    localparam logic [31:0] I_JALR  = 32'h00008067;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    fetch0_stage_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

    fetch0_stage #(.PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v0, input logic v1,
                                  input logic [PC_W-1:0] pc0, input logic [PC_W-1:0] pc1,
                                  input logic [31:0] inst0, input logic [31:0] inst1,
                                  input logic stall, input logic flush);
        bus.iq0_vld_i  = v0;
        bus.iq1_vld_i  = v1;
        bus.iq0_pc_i   = pc0;
        bus.iq1_pc_i   = pc1;
        bus.iq0_inst_i = inst0;
        bus.iq1_inst_i = inst1;
        bus.stall_i    = stall;
        bus.flush_i    = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, '0, '0, I_ADDI, I_ADDI, 1'b0, 1'b0);
    endtask

    // Directed sequence, each step checked one clock after it is applied.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle();
        #12;
        check_output("rst_vld",      64'(bus.f0_vld_o), 64'd0);
        check_output("rst_redir",    64'(bus.redirect_vld_o), 64'd0);
        check_output("rst_flush_iq", 64'(bus.flush_iq_o), 64'd0);
        check_output("rst_flags",    64'({bus.f0_is_br_o, bus.f0_is_jal_o, bus.f0_is_jalr_o}), 64'd0);
        check_output("rst_stall_iq", 64'(bus.stall_iq_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Plain pair goes straight through.
        apply_stimulus(1'b1, 1'b1, 64'h1000, 64'h1004, I_ADDI, I_ADDI, 1'b0, 1'b0);
        tick();
        check_output("pair_vld",   64'(bus.f0_vld_o), 64'd3);
        check_output("pair_pc0",   bus.f0_pc_o[0], 64'h1000);
        check_output("pair_pc1",   bus.f0_pc_o[1], 64'h1004);
        check_output("pair_inst1", 64'(bus.f0_inst_o[1]), 64'(I_ADDI));
        check_output("pair_redir", 64'(bus.redirect_vld_o), 64'd0);
        idle();
        tick();
        check_output("idle_vld", 64'(bus.f0_vld_o), 64'd0);

        // Slot0 JAL +16: slot1 killed, one-cycle redirect.
        apply_stimulus(1'b1, 1'b1, 64'h2000, 64'h2004, I_JAL16, I_ADDI, 1'b0, 1'b0);
        tick();
        check_output("jal0_vld",      64'(bus.f0_vld_o), 64'd1);
        check_output("jal0_isjal",    64'(bus.f0_is_jal_o), 64'd1);
        check_output("jal0_redir",    64'(bus.redirect_vld_o), 64'd1);
        check_output("jal0_tgt",      bus.redirect_pc_o, 64'h2010);
        check_output("jal0_flush_iq", 64'(bus.flush_iq_o), 64'd1);
        check_output("jal0_stall_iq", 64'(bus.stall_iq_o), 64'd1);
        tick();
        check_output("redir_noacc_vld", 64'(bus.f0_vld_o), 64'd0);
        check_output("redir_end",       64'(bus.redirect_vld_o), 64'd0);
        check_output("redir_end_flush", 64'(bus.flush_iq_o), 64'd0);
        check_output("redir_end_stall", 64'(bus.stall_iq_o), 64'd0);
        idle();
        tick();

        // Slot1 JAL -8: both slots survive.
        apply_stimulus(1'b1, 1'b1, 64'h3000, 64'h3004, I_ADDI, I_JALM8, 1'b0, 1'b0);
        tick();
        check_output("jal1_vld",   64'(bus.f0_vld_o), 64'd3);
        check_output("jal1_isjal", 64'(bus.f0_is_jal_o), 64'd2);
        check_output("jal1_redir", 64'(bus.redirect_vld_o), 64'd1);
        check_output("jal1_tgt",   bus.redirect_pc_o, 64'h2FFC);
        idle();
        tick();

        // Both JAL: slot0 wins.
        apply_stimulus(1'b1, 1'b1, 64'h3800, 64'h3804, I_JAL16, I_JALM8, 1'b0, 1'b0);
        tick();
        check_output("jal2_vld", 64'(bus.f0_vld_o), 64'd1);
        check_output("jal2_tgt", bus.redirect_pc_o, 64'h3810);
        idle();
        tick();

        // Branch and JALR are flagged but never redirect.
        apply_stimulus(1'b1, 1'b1, 64'h4000, 64'h4004, I_BEQ, I_JALR, 1'b0, 1'b0);
        tick();
        check_output("brj_vld",   64'(bus.f0_vld_o), 64'd3);
        check_output("brj_br",    64'(bus.f0_is_br_o), 64'd1);
        check_output("brj_jalr",  64'(bus.f0_is_jalr_o), 64'd2);
        check_output("brj_redir", 64'(bus.redirect_vld_o), 64'd0);

        // Decode stall for three cycles with a new pair waiting.
        apply_stimulus(1'b1, 1'b1, 64'h5000, 64'h5004, I_ADDI, I_ADDI, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("stall%0d_pc0", i), bus.f0_pc_o[0], 64'h4000);
            check_output($sformatf("stall%0d_vld", i), 64'(bus.f0_vld_o), 64'd3);
            check_output($sformatf("stall%0d_br", i), 64'(bus.f0_is_br_o), 64'd1);
            check_output($sformatf("stall%0d_siq", i), 64'(bus.stall_iq_o), 64'd1);
        end
        bus.stall_i = 1'b0;
        tick();
        check_output("unstall_pc0", bus.f0_pc_o[0], 64'h5000);
        check_output("unstall_br",  64'(bus.f0_is_br_o), 64'd0);

        // Flush coincident with a slot0 JAL accept.
        apply_stimulus(1'b1, 1'b1, 64'h6000, 64'h6004, I_JAL16, I_ADDI, 1'b0, 1'b1);
        tick();
        check_output("flush_vld",   64'(bus.f0_vld_o), 64'd0);
        check_output("flush_redir", 64'(bus.redirect_vld_o), 64'd0);
        check_output("flush_fiq",   64'(bus.flush_iq_o), 64'd0);
        idle();
        tick();

        // Flush while decode is stalled still clears the valids.
        apply_stimulus(1'b1, 1'b1, 64'h7000, 64'h7004, I_ADDI, I_ADDI, 1'b0, 1'b0);
        tick();
        check_output("pre_sflush_vld", 64'(bus.f0_vld_o), 64'd3);
        apply_stimulus(1'b0, 1'b0, '0, '0, I_ADDI, I_ADDI, 1'b1, 1'b1);
        tick();
        check_output("sflush_vld", 64'(bus.f0_vld_o), 64'd0);
        idle();
        tick();

        // Reset asserted in the redirect cycle.
        apply_stimulus(1'b1, 1'b1, 64'h8000, 64'h8004, I_JAL16, I_ADDI, 1'b0, 1'b0);
        tick();
        check_output("prerst_redir", 64'(bus.redirect_vld_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_redir", 64'(bus.redirect_vld_o), 64'd0);
        check_output("arst_fiq",   64'(bus.flush_iq_o), 64'd0);
        check_output("arst_vld",   64'(bus.f0_vld_o), 64'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_output("post_rst_siq", 64'(bus.stall_iq_o), 64'd0);
        apply_stimulus(1'b1, 1'b1, 64'h9000, 64'h9004, I_ADDI, I_ADDI, 1'b0, 1'b0);
        tick();
        check_output("post_rst_vld", 64'(bus.f0_vld_o), 64'd3);
        check_output("post_rst_pc1", bus.f0_pc_o[1], 64'h9004);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
